// File: rtl/fetch_ctrl.sv
// Program counter / fetch controller with per-program start vectors,
// conditional abs/rel branches and call/return through a small RAS.
module fetch_ctrl #(
    parameter int          PC_W        = 16,
    parameter int          OFF_W       = 8,
    parameter int          RAS_DEPTH   = 4,
    parameter int          NUM_PROGS   = 3,
    parameter int          PSEL_W      = 2,
    parameter int unsigned PROG_STRIDE = 32'h0100
) (
    input  logic                             CLK,
    input  logic                             Init,
    input  logic [PSEL_W-1:0]                Prog_sel,
    input  logic                             Halt,
    input  logic                             FLAG_IN,
    input  logic                             Branch_abs,
    input  logic                             Branch_rel,
    input  logic                             Call,
    input  logic                             Ret,
    input  logic [PC_W-1:0]                  Target,
    input  logic [OFF_W-1:0]                 Offset,
    output logic [PC_W-1:0]                  PC,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   Ras_cnt,
    output logic                             Ras_empty,
    output logic                             Ras_full,
    output logic                             Stack_err
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  ras [RAS_DEPTH];
    logic [PC_W-1:0]  start_pc;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  off_ext;
    logic [PC_W-1:0]  pc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             err_nxt;
    logic             push;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             do_ret;
    logic             do_call;
    logic             do_abs;
    logic             do_rel;

    // Out-of-range program selects fall back to address zero.
    always_comb begin
        start_pc = '0;
        for (int k = 0; k < NUM_PROGS; k++) begin
            if (int'(Prog_sel) == k)
                start_pc = PC_W'(k * PROG_STRIDE);
        end
    end

    assign pc_inc  = PC + PC_W'(1);
    assign off_ext = PC_W'($signed(Offset));
    assign top_idx = IDX_W'(Ras_cnt - CNT_W'(1));
    assign wr_idx  = IDX_W'(Ras_cnt);

    // Flatten the priority chain into one-hot actions.
    assign do_ret  = Ret;
    assign do_call = Call & ~Ret;
    assign do_abs  = Branch_abs & FLAG_IN & ~Call & ~Ret;
    assign do_rel  = Branch_rel & FLAG_IN & ~(Branch_abs & FLAG_IN)
                   & ~Call & ~Ret;

    always_comb begin
        pc_nxt  = pc_inc;
        cnt_nxt = Ras_cnt;
        err_nxt = Stack_err;
        push    = 1'b0;
        if (Init || Halt) begin
            pc_nxt = PC;
        end else begin
            unique case (1'b1)
                do_ret: begin
                    if (Ras_cnt != '0) begin
                        pc_nxt  = ras[top_idx];
                        cnt_nxt = Ras_cnt - CNT_W'(1);
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                do_call: begin
                    if (Ras_cnt != DEPTH_C) begin
                        push    = 1'b1;
                        pc_nxt  = Target;
                        cnt_nxt = Ras_cnt + CNT_W'(1);
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                do_abs: pc_nxt = Target;
                do_rel: pc_nxt = PC + off_ext;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Init) begin
            PC        <= start_pc;
            Ras_cnt   <= '0;
            Stack_err <= 1'b0;
            Ras_empty <= 1'b1;
            Ras_full  <= 1'b0;
        end else begin
            PC        <= pc_nxt;
            Ras_cnt   <= cnt_nxt;
            Stack_err <= err_nxt;
            Ras_empty <= (cnt_nxt == '0);
            Ras_full  <= (cnt_nxt == DEPTH_C);
        end
    end

    always_ff @(posedge CLK) begin
        if (push)
            ras[wr_idx] <= pc_inc;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: expectations queued as stimulus is
// applied, observations queued after each edge, compared per scenario.
module tb_fetch_ctrl;

    logic        CLK;
    logic        Init;
    logic [1:0]  Prog_sel;
    logic        Halt;
    logic        FLAG_IN;
    logic        Branch_abs;
    logic        Branch_rel;
    logic        Call;
    logic        Ret;
    logic [15:0] Target;
    logic [7:0]  Offset;
    logic [15:0] PC;
    logic [2:0]  Ras_cnt;
    logic        Ras_empty;
    logic        Ras_full;
    logic        Stack_err;

    typedef struct packed {
        logic [15:0] pc;
        logic [2:0]  cnt;
        logic        err;
        logic        empty;
        logic        full;
    } obs_t;

    obs_t exp_q[$];
    obs_t obs_q[$];
    int   checks   = 0;
    int   failures = 0;

    fetch_ctrl dut (
        .CLK        (CLK),
        .Init       (Init),
        .Prog_sel   (Prog_sel),
        .Halt       (Halt),
        .FLAG_IN    (FLAG_IN),
        .Branch_abs (Branch_abs),
        .Branch_rel (Branch_rel),
        .Call       (Call),
        .Ret        (Ret),
        .Target     (Target),
        .Offset     (Offset),
        .PC         (PC),
        .Ras_cnt    (Ras_cnt),
        .Ras_empty  (Ras_empty),
        .Ras_full   (Ras_full),
        .Stack_err  (Stack_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step(input string op, input logic [15:0] a,
                        input logic [15:0] pc, input logic [2:0] cnt,
                        input logic err);
        obs_t e;
        obs_t o;
        Init = 0; Halt = 0; FLAG_IN = 0; Branch_abs = 0;
        Branch_rel = 0; Call = 0; Ret = 0; Prog_sel = 2'd0;
        Target = a;
        Offset = a[7:0];
        case (op)
            "INIT":  begin Init = 1; Prog_sel = a[1:0]; end
            "INITH": begin Init = 1; Halt = 1; Call = 1; Prog_sel = a[1:0]; end
            "ABS":   begin Branch_abs = 1; FLAG_IN = 1; end
            "ABS0":  Branch_abs = 1;
            "REL":   begin Branch_rel = 1; FLAG_IN = 1; end
            "REL0":  Branch_rel = 1;
            "BOTH":  begin Branch_abs = 1; Branch_rel = 1; FLAG_IN = 1; end
            "CALL":  Call = 1;
            "RET":   Ret = 1;
            "CR":    begin Call = 1; Ret = 1; end
            "HALT":  begin Halt = 1; Call = 1; Ret = 1; Branch_abs = 1; FLAG_IN = 1; end
            default: ;
        endcase
        e.pc = pc; e.cnt = cnt; e.err = err;
        e.empty = (cnt == 3'd0);
        e.full  = (cnt == 3'd4);
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        o.pc = PC; o.cnt = Ras_cnt; o.err = Stack_err;
        o.empty = Ras_empty; o.full = Ras_full;
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        obs_t e;
        obs_t o;
        int n = 0;
        step("INIT", 16'd2, 16'h0200, 3'd0, 1'b0);
        step("NOP",  16'd0, 16'h0201, 3'd0, 1'b0);
        step("NOP",  16'd0, 16'h0202, 3'd0, 1'b0);
        step("NOP",  16'd0, 16'h0203, 3'd0, 1'b0);
        step("INIT", 16'd3, 16'h0000, 3'd0, 1'b0);
        step("INIT", 16'd1, 16'h0100, 3'd0, 1'b0);
        step("INIT", 16'd0, 16'h0000, 3'd0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; n++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset[%0d] got pc=%h cnt=%0d err=%b emp=%b full=%b want pc=%h cnt=%0d err=%b emp=%b full=%b",
                         n, o.pc, o.cnt, o.err, o.empty, o.full, e.pc, e.cnt, e.err, e.empty, e.full);
            end
        end
    endtask

    task automatic test_branch();
        obs_t e;
        obs_t o;
        int n = 0;
        step("ABS",  16'h0010, 16'h0010, 3'd0, 1'b0);
        step("REL",  16'h00FC, 16'h000C, 3'd0, 1'b0);
        step("ABS",  16'h0010, 16'h0010, 3'd0, 1'b0);
        step("REL0", 16'h00FC, 16'h0011, 3'd0, 1'b0);
        step("ABS0", 16'h5555, 16'h0012, 3'd0, 1'b0);
        step("REL",  16'h0005, 16'h0017, 3'd0, 1'b0);
        step("BOTH", 16'h0040, 16'h0040, 3'd0, 1'b0);
        step("REL",  16'h0080, 16'hFFC0, 3'd0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; n++;
            if (o !== e) begin
                failures++;
                $display("FAIL branch[%0d] got pc=%h cnt=%0d err=%b emp=%b full=%b want pc=%h cnt=%0d err=%b emp=%b full=%b",
                         n, o.pc, o.cnt, o.err, o.empty, o.full, e.pc, e.cnt, e.err, e.empty, e.full);
            end
        end
    endtask

    task automatic test_call_ret();
        obs_t e;
        obs_t o;
        int n = 0;
        step("ABS",  16'h0020, 16'h0020, 3'd0, 1'b0);
        step("CALL", 16'h0100, 16'h0100, 3'd1, 1'b0);
        for (int i = 1; i <= 5; i++)
            step("NOP", 16'h0000, 16'h0100 + 16'(i), 3'd1, 1'b0);
        step("RET",  16'h0000, 16'h0021, 3'd0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; n++;
            if (o !== e) begin
                failures++;
                $display("FAIL call_ret[%0d] got pc=%h cnt=%0d err=%b emp=%b full=%b want pc=%h cnt=%0d err=%b emp=%b full=%b",
                         n, o.pc, o.cnt, o.err, o.empty, o.full, e.pc, e.cnt, e.err, e.empty, e.full);
            end
        end
    endtask

    task automatic test_nested();
        obs_t e;
        obs_t o;
        int n = 0;
        step("INIT", 16'd0,    16'h0000, 3'd0, 1'b0);
        step("CALL", 16'h1000, 16'h1000, 3'd1, 1'b0);
        step("CALL", 16'h2000, 16'h2000, 3'd2, 1'b0);
        step("CALL", 16'h3000, 16'h3000, 3'd3, 1'b0);
        step("CALL", 16'h4000, 16'h4000, 3'd4, 1'b0);
        step("CALL", 16'h5000, 16'h4001, 3'd4, 1'b1);
        step("RET",  16'h0000, 16'h3001, 3'd3, 1'b1);
        step("RET",  16'h0000, 16'h2001, 3'd2, 1'b1);
        step("RET",  16'h0000, 16'h1001, 3'd1, 1'b1);
        step("RET",  16'h0000, 16'h0001, 3'd0, 1'b1);
        step("RET",  16'h0000, 16'h0002, 3'd0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; n++;
            if (o !== e) begin
                failures++;
                $display("FAIL nested[%0d] got pc=%h cnt=%0d err=%b emp=%b full=%b want pc=%h cnt=%0d err=%b emp=%b full=%b",
                         n, o.pc, o.cnt, o.err, o.empty, o.full, e.pc, e.cnt, e.err, e.empty, e.full);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e;
        obs_t o;
        int n = 0;
        step("INIT", 16'd0,    16'h0000, 3'd0, 1'b0);
        step("CALL", 16'h0800, 16'h0800, 3'd1, 1'b0);
        step("CR",   16'h0900, 16'h0001, 3'd0, 1'b0);
        step("CALL", 16'h0A00, 16'h0A00, 3'd1, 1'b0);
        step("CALL", 16'h0B00, 16'h0B00, 3'd2, 1'b0);
        step("RET",  16'h0000, 16'h0A01, 3'd1, 1'b0);
        step("RET",  16'h0000, 16'h0002, 3'd0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; n++;
            if (o !== e) begin
                failures++;
                $display("FAIL back_to_back[%0d] got pc=%h cnt=%0d err=%b emp=%b full=%b want pc=%h cnt=%0d err=%b emp=%b full=%b",
                         n, o.pc, o.cnt, o.err, o.empty, o.full, e.pc, e.cnt, e.err, e.empty, e.full);
            end
        end
    endtask

    task automatic test_wrap_halt();
        obs_t e;
        obs_t o;
        int n = 0;
        step("ABS",  16'hFFFF, 16'hFFFF, 3'd0, 1'b0);
        step("NOP",  16'h0000, 16'h0000, 3'd0, 1'b0);
        step("ABS",  16'hFFFE, 16'hFFFE, 3'd0, 1'b0);
        step("REL",  16'h0005, 16'h0003, 3'd0, 1'b0);
        step("ABS",  16'hFFFF, 16'hFFFF, 3'd0, 1'b0);
        step("CALL", 16'h0040, 16'h0040, 3'd1, 1'b0);
        step("HALT", 16'h1234, 16'h0040, 3'd1, 1'b0);
        step("HALT", 16'h1234, 16'h0040, 3'd1, 1'b0);
        step("RET",  16'h0000, 16'h0000, 3'd0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; n++;
            if (o !== e) begin
                failures++;
                $display("FAIL wrap_halt[%0d] got pc=%h cnt=%0d err=%b emp=%b full=%b want pc=%h cnt=%0d err=%b emp=%b full=%b",
                         n, o.pc, o.cnt, o.err, o.empty, o.full, e.pc, e.cnt, e.err, e.empty, e.full);
            end
        end
    endtask

    task automatic test_init_midcall();
        obs_t e;
        obs_t o;
        int n = 0;
        step("INIT",  16'd0,    16'h0000, 3'd0, 1'b0);
        step("RET",   16'h0000, 16'h0001, 3'd0, 1'b1);
        step("CALL",  16'h0010, 16'h0010, 3'd1, 1'b1);
        step("CALL",  16'h0020, 16'h0020, 3'd2, 1'b1);
        step("CALL",  16'h0030, 16'h0030, 3'd3, 1'b1);
        step("INITH", 16'd1,    16'h0100, 3'd0, 1'b0);
        step("RET",   16'h0000, 16'h0101, 3'd0, 1'b1);
        step("INIT",  16'd2,    16'h0200, 3'd0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; n++;
            if (o !== e) begin
                failures++;
                $display("FAIL init_midcall[%0d] got pc=%h cnt=%0d err=%b emp=%b full=%b want pc=%h cnt=%0d err=%b emp=%b full=%b",
                         n, o.pc, o.cnt, o.err, o.empty, o.full, e.pc, e.cnt, e.err, e.empty, e.full);
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_call_ret();
        test_nested();
        test_back_to_back();
        test_wrap_halt();
        test_init_midcall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
